// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared types and register-map constants for the UART transmitter
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam logic [3:0] UART_DATA_OFS   = 4'h0;
  localparam logic [3:0] UART_STATUS_OFS = 4'h4;
  localparam logic [3:0] UART_DIV_OFS    = 4'h8;

  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  // Word select within the 16-byte window; byte-lane bits are ignored.
  function automatic logic [1:0] reg_sel(input logic [3:0] a);
    return a[3:2];
  endfunction

endpackage

`default_nettype wire

// File: rtl/byte_fifo.sv
// ============================================================================
// byte_fifo : circular-buffer FIFO with extra-MSB pointers for full/empty
// Revision  : 1.0
// ============================================================================
`default_nettype none

module byte_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int WIDTH      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int         AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  // A push into a full FIFO is dropped even when a pop frees a slot that cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wptr[AW-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_mmap.sv
// ============================================================================
// uart_tx_mmap : memory-mapped 8N1 UART transmitter with byte FIFO.
//                Optional even parity bit when UART_TX_PARITY_EN is defined.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module uart_tx_mmap
  import uart_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd278
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        re,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        tx
);

  uart_state_t state, state_n;
  logic [15:0] div, baud_cnt, baud_n, baud_step;
  logic [7:0]  shift, shift_n, fifo_dout;
  logic [2:0]  bit_cnt, bit_n;
  logic        par_bit, par_n, par_en;
  logic        ovf, full, empty, pop, push, div_we, stat_we, tick;
  logic        unused_bits;

  assign push        = we && (reg_sel(addr) == reg_sel(UART_DATA_OFS));
  assign stat_we     = we && (reg_sel(addr) == reg_sel(UART_STATUS_OFS));
  assign div_we      = we && (reg_sel(addr) == reg_sel(UART_DIV_OFS));
  assign tick        = (baud_cnt == 16'd0);
  // DIV is sampled only at reload, so a mid-bit change never stretches the current bit.
  assign baud_step   = tick ? (div - 16'd1) : (baud_cnt - 16'd1);
  assign unused_bits = ^{wd[31:16], addr[1:0]};

  byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (wd[7:0]),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    shift_n = shift;
    bit_n   = bit_cnt;
    par_n   = par_bit;
    pop     = 1'b0;
    tx      = 1'b1;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = START;
          shift_n = fifo_dout;
          par_n   = ^fifo_dout;
          baud_n  = div - 16'd1;
          bit_n   = 3'd0;
        end
      end
      START: begin
        tx     = 1'b0;
        baud_n = baud_step;
        if (tick) state_n = DATA;
      end
      DATA: begin
        tx     = shift[0];
        baud_n = baud_step;
        if (tick) begin
          shift_n = {1'b0, shift[7:1]};
          bit_n   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = par_en ? PARITY : STOP;
        end
      end
      PARITY: begin
        tx     = par_bit;
        baud_n = baud_step;
        if (tick) state_n = STOP;
      end
      STOP: begin
        baud_n = baud_step;
        if (tick) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      shift    <= '0;
      bit_cnt  <= '0;
      par_bit  <= 1'b0;
      ovf      <= 1'b0;
      div      <= DEFAULT_DIV;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      shift    <= shift_n;
      bit_cnt  <= bit_n;
      par_bit  <= par_n;
      if (push && full)          ovf <= 1'b1;
      else if (stat_we && wd[3]) ovf <= 1'b0;
      if (div_we) div <= (wd[15:0] == 16'd0) ? 16'd1 : wd[15:0];
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset)       par_en <= 1'b0;
    else if (div_we) par_en <= wd[16];
  end
`else
  assign par_en = 1'b0;
`endif

  always_comb begin
    rd = '0;
    if (re) begin
      case (reg_sel(addr))
        reg_sel(UART_STATUS_OFS): begin
          rd[STAT_FULL]  = full;
          rd[STAT_EMPTY] = empty;
          rd[STAT_BUSY]  = (state != IDLE);
          rd[STAT_OVF]   = ovf;
        end
        reg_sel(UART_DIV_OFS): begin
          rd[15:0] = div;
          rd[16]   = par_en;
        end
        default: rd = '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_mmap.sv
// ============================================================================
// tb_uart_tx_mmap : scoreboard bench; register reads and tx frames are checked
//                   by monitors against queues filled by the stimulus.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_mmap;

  logic        clk = 1'b0;
  logic        reset, re, we, tx;
  logic [3:0]  addr;
  logic [31:0] wd, rd;

  int checks = 0;
  int errors = 0;

  logic [31:0] q_rd[$];
  string       q_rdn[$];
  logic [7:0]  q_byte[$];
  int          q_nbits[$];
  int          q_len[$];
  int          q_gap[$];
  bit          mon_off  = 1'b0;
  bit          in_frame = 1'b0;

  uart_tx_mmap #(.FIFO_DEPTH(8), .DEFAULT_DIV(16'd278)) dut (
    .clk   (clk),
    .reset (reset),
    .re    (re),
    .we    (we),
    .addr  (addr),
    .wd    (wd),
    .rd    (rd),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wd = d;
    @(posedge clk); #1;
    we = 1'b0; addr = 4'h0; wd = 32'h0;
  endtask

  task automatic rdc(input logic [3:0] a, input logic [31:0] e, input string nm);
    q_rd.push_back(e);
    q_rdn.push_back(nm);
    re = 1'b1; addr = a;
    @(posedge clk); #1;
    re = 1'b0; addr = 4'h0;
  endtask

  task automatic exp_frame(input logic [7:0] b, input int nb, input int d, input int gap);
    q_byte.push_back(b);
    q_nbits.push_back(nb);
    q_gap.push_back(gap);
    for (int k = 0; k < nb; k++) q_len.push_back(d);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((q_nbits.size() != 0 || in_frame) && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL wait_idle timeout actual=%0d frames pending required=0", q_nbits.size());
    end
  endtask

  // Read monitor: every cycle with re asserted is one register response.
  always @(negedge clk) begin
    if (re) begin
      if (q_rd.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected actual=%h required=no read", rd);
      end else begin
        chk(q_rdn.pop_front(), rd, q_rd.pop_front());
      end
    end
  end

  // Frame monitor: checks every cycle of each bit against the expected level and length.
  initial begin : frame_mon
    logic        prev;
    logic        bad, bad_val;
    logic [10:0] lvl;
    logic [7:0]  b;
    int          idle, nb, len, gap, bad_c;
    prev = 1'b1;
    idle = 0;
    forever begin
      @(negedge clk);
      if (reset || mon_off) begin
        idle = 0;
      end else if (prev && !tx) begin
        if (q_nbits.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_unexpected actual=start bit at %0t required=idle line", $time);
        end else begin
          in_frame = 1'b1;
          nb  = q_nbits.pop_front();
          b   = q_byte.pop_front();
          gap = q_gap.pop_front();
          if (gap >= 0) chk("frame_gap", 32'(idle), 32'(gap));
          lvl    = '1;
          lvl[0] = 1'b0;
          for (int i = 0; i < 8; i++) lvl[i+1] = b[i];
          if (nb == 11) lvl[9] = ^b;
          for (int k = 0; k < nb; k++) begin
            len = q_len.pop_front();
            bad = 1'b0; bad_val = 1'b0; bad_c = 0;
            for (int c = 0; c < len; c++) begin
              if (k != 0 || c != 0) @(negedge clk);
              if (tx !== lvl[k] && !bad) begin
                bad = 1'b1; bad_val = tx; bad_c = c;
              end
            end
            checks++;
            if (bad) begin
              errors++;
              $display("FAIL frame_bit%0d byte=%02h actual=%0b at cycle %0d required=%0b for %0d cycles",
                       k, b, bad_val, bad_c, lvl[k], len);
            end
          end
          in_frame = 1'b0;
        end
        idle = 0;
      end else if (tx) begin
        idle++;
      end
      prev = tx;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bad;
    re = 1'b0; we = 1'b0; addr = 4'h0; wd = 32'h0; reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    chk("reset_tx", 32'(tx), 32'h1);
    rdc(4'h4, 32'h2, "reset_status");
    rdc(4'h8, 32'd278, "reset_div");
    rdc(4'h0, 32'h0, "data_reads_zero");
    rdc(4'hC, 32'h0, "reserved_reads_zero");

    // Single byte, latency and busy
    wr(4'h8, 32'd4);
    rdc(4'h8, 32'd4, "div4_readback");
    exp_frame(8'h55, 10, 4, -1);
    wr(4'h0, 32'h55);
    @(negedge clk); chk("latency_n1_tx_high", 32'(tx), 32'h1);
    @(negedge clk); chk("latency_n2_tx_low", 32'(tx), 32'h0);
    @(posedge clk); #1;
    rdc(4'h4, 32'h6, "status_busy");
    wait_idle(200);
    rdc(4'h4, 32'h2, "status_after_frame");

    // Back-to-back frames with one idle cycle between
    wr(4'h8, 32'd2);
    exp_frame(8'hA5, 10, 2, -1);
    exp_frame(8'h3C, 10, 2, 1);
    wr(4'h0, 32'hA5);
    wr(4'h0, 32'h3C);
    wait_idle(200);

    // Overflow: byte 9 dropped, flag sticky until wd[3] write
    wr(4'h8, 32'd100);
    for (int i = 0; i < 9; i++) exp_frame(8'(i), 10, 100, (i == 0) ? -1 : 1);
    for (int i = 0; i < 10; i++) wr(4'h0, 32'(i));
    rdc(4'h4, 32'hD, "ovf_status");
    wr(4'h4, 32'h0);
    rdc(4'h4, 32'hD, "ovf_sticky");
    wr(4'h4, 32'h8);
    rdc(4'h4, 32'h5, "ovf_cleared");
    wait_idle(12000);
    rdc(4'h4, 32'h2, "status_after_ovf");

    // DIV=0 stored as 1
    wr(4'h8, 32'd0);
    rdc(4'h8, 32'd1, "div0_reads_one");
    exp_frame(8'h96, 10, 1, -1);
    wr(4'h0, 32'h96);
    wait_idle(100);

    // DIV 4 -> 8 during data bit 0: bit 0 keeps 4 cycles
    wr(4'h8, 32'd4);
    q_byte.push_back(8'hC3); q_nbits.push_back(10); q_gap.push_back(-1);
    q_len.push_back(4); q_len.push_back(4);
    for (int k = 0; k < 8; k++) q_len.push_back(8);
    wr(4'h0, 32'hC3);
    repeat (6) @(posedge clk);
    #1;
    wr(4'h8, 32'd8);
    wait_idle(300);

    // Reset during data bit 3
    wr(4'h8, 32'd4);
    mon_off = 1'b1;
    wr(4'h0, 32'h55);
    repeat (18) @(posedge clk);
    #1;
    chk("pre_reset_bit3", 32'(tx), 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("reset_midframe_tx", 32'(tx), 32'h1);
    rdc(4'h4, 32'h2, "reset_midframe_status");
    rdc(4'h8, 32'd278, "reset_midframe_div");
    bad = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) bad = 1'b1;
    end
    chk("no_residual_frame", 32'(bad), 32'h0);
    @(posedge clk); #1;
    mon_off = 1'b0;

`ifdef UART_TX_PARITY_EN
    wr(4'h8, 32'h10003);
    rdc(4'h8, 32'h10003, "div_parity_readback");
    exp_frame(8'h07, 11, 3, -1);
    wr(4'h0, 32'h07);
    wait_idle(200);
    wr(4'h8, 32'd3);
    rdc(4'h8, 32'd3, "div_parity_off");
    exp_frame(8'h07, 10, 3, -1);
    wr(4'h0, 32'h07);
    wait_idle(200);
`else
    wr(4'h8, 32'h10003);
    rdc(4'h8, 32'd3, "div_bit16_ignored");
    exp_frame(8'h07, 10, 3, -1);
    wr(4'h0, 32'h07);
    wait_idle(200);
`endif

    repeat (50) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
